// File: rtl/dma_cmd_tx.sv
// Host-side transmitter for the DMA command byte protocol.
// Turns block requests plus a payload stream into registered {op,0,addr} command bytes and aligned data bytes.
module dma_cmd_tx #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [7:0]        cmd_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_START,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic [LEN_W-1:0]    len_sat;
  logic [3:0]          addr_field;

  assign len_sat    = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  assign addr_field = 4'(addr_q);

  assign req_ready  = (state_q == S_IDLE);
  assign data_ready = (state_q == S_XFER);
  assign busy       = (state_q != S_IDLE);
  assign cmd_out    = cmd_q;
  assign data_out   = data_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    cmd_d   = 8'h00;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = {1'b0, req_op} + 3'd1;
          addr_d = req_base;
          cnt_d  = len_sat;
          if (req_op == 2'd3)        state_d = S_START;
          else if (len_sat == '0)    state_d = S_DONE;
          else                       state_d = S_LOAD;
        end
      end
      // One settle cycle so word 0 lands two edges after acceptance.
      S_LOAD: state_d = S_XFER;
      S_XFER: begin
        if (data_valid) begin
          cmd_d  = {op_q, 1'b0, addr_field};
          data_d = data_in;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_START: begin
        cmd_d   = 8'h80;
        data_d  = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      cmd_q   <= 8'h00;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_dma_cmd_tx.sv
// Directed bench for dma_cmd_tx: per-cycle vector table plus hand sequences for
// saturation and mid-transfer reset.
module tb_dma_cmd_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_base;
  logic [4:0] req_len;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] cmd_out;
  logic [7:0] data_out;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  dma_cmd_tx #(.ADDR_W(4), .DATA_W(8), .LEN_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_len(req_len),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .cmd_out(cmd_out), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic [1:0] op;
    logic [3:0] base;
    logic [4:0] len;
    logic       dv;
    logic [7:0] din;
    logic [7:0] cmd;
    logic [7:0] dout;
    logic       rr;
    logic       dr;
    logic       bz;
    logic       dn;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rv, input logic [1:0] op, input logic [3:0] base,
                              input logic [4:0] len, input logic dv, input logic [7:0] din,
                              input logic [7:0] cmd, input logic [7:0] dout,
                              input logic rr, input logic dr, input logic bz, input logic dn);
    vec_t v;
    v.rv = rv; v.op = op; v.base = base; v.len = len; v.dv = dv; v.din = din;
    v.cmd = cmd; v.dout = dout; v.rr = rr; v.dr = dr; v.bz = bz; v.dn = dn;
    return v;
  endfunction

  // Idle inputs, only expected outputs given.
  function automatic vec_t ik(input logic [7:0] cmd, input logic [7:0] dout,
                              input logic rr, input logic dr, input logic bz, input logic dn);
    return mk(1'b0, 2'd0, 4'd0, 5'd0, 1'b0, 8'h00, cmd, dout, rr, dr, bz, dn);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    int  words;
    int  sent;
    bit  hs_pending;
    bit  seen_done;
    bit  found;
    bit  bad_after;

    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_base = 4'd0; req_len = 5'd0;
    data_in = 8'h00; data_valid = 1'b0;
    #12;
    chk("reset_cmd", 32'(cmd_out), 32'h00);
    chk("reset_flags", {28'd0, req_ready, data_ready, busy, done}, 32'b1000);
    chk("reset_dout", 32'(data_out), 32'h00);
    @(negedge clk);
    reset = 1'b0;

    // op0 base0 len3, back-to-back bytes
    vq.push_back(mk(1, 0, 0, 3, 1, 8'hA1, 8'h00, 8'h00, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'hA1, 8'h00, 8'h00, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'hA1, 8'h00, 8'h00, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'hA2, 8'h20, 8'hA1, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'hA3, 8'h21, 8'hA2, 0, 1, 1, 0));
    vq.push_back(ik(8'h22, 8'hA3, 0, 0, 1, 0));
    vq.push_back(ik(8'h00, 8'hA3, 1, 0, 0, 1));
    vq.push_back(ik(8'h00, 8'hA3, 1, 0, 0, 0));
    // op1 base2 len3 with a two-cycle gap before the second byte
    vq.push_back(mk(1, 1, 2, 3, 0, 8'h00, 8'h00, 8'hA3, 1, 0, 0, 0));
    vq.push_back(ik(8'h00, 8'hA3, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h11, 8'h00, 8'hA3, 0, 1, 1, 0));
    vq.push_back(ik(8'h42, 8'h11, 0, 1, 1, 0));
    vq.push_back(ik(8'h00, 8'h11, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h22, 8'h00, 8'h11, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h33, 8'h43, 8'h22, 0, 1, 1, 0));
    vq.push_back(ik(8'h44, 8'h33, 0, 0, 1, 0));
    vq.push_back(ik(8'h00, 8'h33, 1, 0, 0, 1));
    // op2 base14 len4, address wrap
    vq.push_back(mk(1, 2, 14, 4, 0, 8'h00, 8'h00, 8'h33, 1, 0, 0, 0));
    vq.push_back(ik(8'h00, 8'h33, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'hC0, 8'h00, 8'h33, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'hC1, 8'h6E, 8'hC0, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'hC2, 8'h6F, 8'hC1, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'hC3, 8'h60, 8'hC2, 0, 1, 1, 0));
    vq.push_back(ik(8'h61, 8'hC3, 0, 0, 1, 0));
    vq.push_back(ik(8'h00, 8'hC3, 1, 0, 0, 1));
    // op3 start with req_valid held through busy
    vq.push_back(mk(1, 3, 0, 0, 0, 8'h00, 8'h00, 8'hC3, 1, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0, 0, 8'h00, 8'h00, 8'hC3, 0, 0, 1, 0));
    vq.push_back(mk(1, 3, 0, 0, 0, 8'h00, 8'h80, 8'h00, 0, 0, 1, 0));
    vq.push_back(ik(8'h00, 8'h00, 1, 0, 0, 1));
    vq.push_back(ik(8'h00, 8'h00, 1, 0, 0, 0));
    // op0 len0: straight to done
    vq.push_back(mk(1, 0, 5, 0, 1, 8'h77, 8'h00, 8'h00, 1, 0, 0, 0));
    vq.push_back(ik(8'h00, 8'h00, 0, 0, 1, 0));
    vq.push_back(ik(8'h00, 8'h00, 1, 0, 0, 1));
    vq.push_back(ik(8'h00, 8'h00, 1, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      req_valid = vq[i].rv; req_op = vq[i].op; req_base = vq[i].base; req_len = vq[i].len;
      data_valid = vq[i].dv; data_in = vq[i].din;
      @(negedge clk);
      n_vec++;
      if (cmd_out !== vq[i].cmd || data_out !== vq[i].dout || req_ready !== vq[i].rr ||
          data_ready !== vq[i].dr || busy !== vq[i].bz || done !== vq[i].dn) begin
        n_err++;
        $display("FAIL vec%0d: got cmd=%h dout=%h rr=%b dr=%b busy=%b done=%b want cmd=%h dout=%h rr=%b dr=%b busy=%b done=%b",
                 i, cmd_out, data_out, req_ready, data_ready, busy, done,
                 vq[i].cmd, vq[i].dout, vq[i].rr, vq[i].dr, vq[i].bz, vq[i].dn);
      end
    end

    // len=31 saturates to 16 words, addresses 0..15
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_op = 2'd0; req_base = 4'd0; req_len = 5'd31;
    data_valid = 1'b1; data_in = 8'h80;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    words = 0; sent = 0; hs_pending = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      @(posedge clk);
      if (hs_pending) sent++;
      #1;
      data_in = 8'(8'h80 + sent);
      @(negedge clk);
      hs_pending = data_ready & data_valid;
      if (cmd_out != 8'h00) begin
        chk($sformatf("sat_cmd%0d", words), 32'(cmd_out), 32'({3'b001, 1'b0, 4'(words)}));
        chk($sformatf("sat_dat%0d", words), 32'(data_out), 32'(8'h80 + words));
        words++;
      end
      if (done) seen_done = 1'b1;
    end
    data_valid = 1'b0;
    chk("sat_words", 32'(words), 32'd16);
    chk("sat_done_seen", 32'(seen_done), 32'd1);

    // reset in the middle of a transfer
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_op = 2'd0; req_base = 4'd3; req_len = 5'd5;
    data_valid = 1'b1; data_in = 8'h5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (cmd_out == 8'h24) found = 1'b1;
    end
    chk("rst_pre_cmd", 32'(cmd_out), 32'h24);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_cmd", 32'(cmd_out), 32'h00);
    chk("rst_dout", 32'(data_out), 32'h00);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    data_valid = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    bad_after = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cmd_out != 8'h00 || done || busy) bad_after = 1'b1;
    end
    chk("rst_quiet_after", 32'(bad_after), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
